// File: rtl/mmio_pkt_injector.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mmio_pkt_injector : CPU-less MMIO programmer for NUM_PKTS NI packet transfers
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module mmio_pkt_injector #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] REG_BASE    = '0,
  parameter int                NUM_PKTS    = 4,
  parameter logic [DATA_W-1:0] PKT_BASE    = 32'd67890,
  parameter logic [DATA_W-1:0] PKT_STRIDE  = 32'd64,
  parameter logic [DATA_W-1:0] NBYTES      = 32'd12,
  parameter logic [DATA_W-1:0] TIMER_BASE  = 32'd30,
  parameter logic [DATA_W-1:0] TIMER_STEP  = 32'd0,
  parameter bit                WAIT_IRQ    = 1'b1,
  parameter int                GAP_CYCLES  = 8,
  parameter int                IRQ_TIMEOUT = 1024
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            start_i,
  input  logic                            irq_i,
  output logic [ADDR_W-1:0]               mmio_addr_o,
  output logic [DATA_W-1:0]               mmio_data_o,
  output logic                            mmio_wb_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            timeout_o,
  output logic [$clog2(NUM_PKTS+1)-1:0]   pkt_cnt_o
);

  localparam int IDX_W   = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
  localparam int CNT_MAX = (IRQ_TIMEOUT > GAP_CYCLES) ? IRQ_TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PCNT_W  = $clog2(NUM_PKTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PKTS - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(IRQ_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_ADDR   = 3'd1,
    S_WR_NBYTES = 3'd2,
    S_WR_TIMER  = 3'd3,
    S_WAIT      = 3'd4,
    S_GAP       = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PCNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
  logic                timeout_q, timeout_d;
  logic                irq_q;
  logic                irq_pend_q, irq_pend_d;
  logic                irq_edge, ack;
  logic [ADDR_W-1:0]   mmio_addr_q, mmio_addr_d;
  logic [DATA_W-1:0]   mmio_data_q, mmio_data_d;
  logic                mmio_wb_q, mmio_wb_d;
  logic                busy_q, done_q;

  assign irq_edge = irq_i & ~irq_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    timeout_d  = timeout_q;
    irq_pend_d = irq_pend_q;
    ack        = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d    = S_WR_ADDR;
          idx_d      = '0;
          pkt_cnt_d  = '0;
          timeout_d  = 1'b0;
          irq_pend_d = 1'b0;
        end
      end
      S_WR_ADDR: begin
        state_d = S_WR_NBYTES;
        if (irq_edge) irq_pend_d = 1'b1;
      end
      S_WR_NBYTES: begin
        state_d = S_WR_TIMER;
        if (irq_edge) irq_pend_d = 1'b1;
      end
      S_WR_TIMER: begin
        state_d = WAIT_IRQ ? S_WAIT : S_GAP;
        cnt_d   = '0;
        if (irq_edge) irq_pend_d = 1'b1;
      end
      S_WAIT: begin
        // A pending or fresh edge beats a timeout landing on the same cycle.
        if (irq_pend_q || irq_edge) begin
          ack = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) ack = 1'b1;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (ack) begin
      pkt_cnt_d  = pkt_cnt_q + PCNT_W'(1);
      irq_pend_d = 1'b0;
      if (idx_q == LAST_IDX) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = S_WR_ADDR;
      end
    end
  end

  // Write bus is registered from the next state so the strobe lines up with it.
  always_comb begin
    mmio_wb_d   = 1'b0;
    mmio_addr_d = mmio_addr_q;
    mmio_data_d = mmio_data_q;
    case (state_d)
      S_WR_ADDR: begin
        mmio_wb_d   = 1'b1;
        mmio_addr_d = REG_BASE;
        mmio_data_d = PKT_BASE + DATA_W'(idx_d) * PKT_STRIDE;
      end
      S_WR_NBYTES: begin
        mmio_wb_d   = 1'b1;
        mmio_addr_d = REG_BASE + ADDR_W'(4);
        mmio_data_d = NBYTES;
      end
      S_WR_TIMER: begin
        mmio_wb_d   = 1'b1;
        mmio_addr_d = REG_BASE + ADDR_W'(8);
        mmio_data_d = TIMER_BASE + DATA_W'(idx_d) * TIMER_STEP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      pkt_cnt_q   <= '0;
      timeout_q   <= 1'b0;
      irq_q       <= 1'b0;
      irq_pend_q  <= 1'b0;
      mmio_addr_q <= '0;
      mmio_data_q <= '0;
      mmio_wb_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      timeout_q   <= timeout_d;
      irq_q       <= irq_i;
      irq_pend_q  <= irq_pend_d;
      mmio_addr_q <= mmio_addr_d;
      mmio_data_q <= mmio_data_d;
      mmio_wb_q   <= mmio_wb_d;
      busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign mmio_addr_o = mmio_addr_q;
  assign mmio_data_o = mmio_data_q;
  assign mmio_wb_o   = mmio_wb_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;
  assign pkt_cnt_o   = pkt_cnt_q;

endmodule
`default_nettype wire
